// File: rtl/safe_lock_ctrl.sv
// Safe-box password controller: keypad entry buffer, password compare, open/set/lockout sequencing.
// Latency: one cycle from sampled strobe to visible outputs. No backpressure; every strobe is acted on or dropped.
module safe_lock_ctrl #(
    parameter logic [15:0] DEFAULT_PW     = 16'h1234,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 500000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       key_enter,
    input  logic       key_clear,
    input  logic       key_set,
    input  logic       door_close,
    output logic [3:0] p0,
    output logic [3:0] p1,
    output logic [3:0] p2,
    output logic [3:0] p3,
    output logic       show_digits,
    output logic       unlocked,
    output logic       alarm,
    output logic [2:0] entry_cnt,
    output logic [2:0] fail_cnt
);

    localparam logic [1:0]  ST_ENTRY   = 2'd0;
    localparam logic [1:0]  ST_OPEN    = 2'd1;
    localparam logic [1:0]  ST_SET_PW  = 2'd2;
    localparam logic [1:0]  ST_LOCKOUT = 2'd3;
    localparam logic [2:0]  MAX_F      = 3'(MAX_FAILS);
    localparam logic [31:0] LOCK_LEN   = 32'(LOCKOUT_CYCLES);

    logic [1:0]  state, state_n;
    logic [15:0] pw, pw_n;
    logic [15:0] entry_buf, entry_buf_n;
    logic [2:0]  entry_cnt_n, fail_cnt_n;
    logic [31:0] timer, timer_n;
    logic [15:0] disp_n;
    logic        digit_ok;

    assign digit_ok = key_valid && (key_code <= 4'd9) && (entry_cnt < 3'd4);

    always_comb begin
        state_n     = state;
        pw_n        = pw;
        entry_buf_n = entry_buf;
        entry_cnt_n = entry_cnt;
        fail_cnt_n  = fail_cnt;
        timer_n     = timer;
        case (state)
            ST_ENTRY: begin
                if (key_clear) begin
                    entry_buf_n = '0;
                    entry_cnt_n = '0;
                end else if (key_enter) begin
                    if (entry_cnt == 3'd4) begin
                        entry_buf_n = '0;
                        entry_cnt_n = '0;
                        if (entry_buf == pw) begin
                            state_n    = ST_OPEN;
                            fail_cnt_n = '0;
                        end else begin
                            fail_cnt_n = (fail_cnt < MAX_F) ? fail_cnt + 3'd1 : fail_cnt;
                            if (fail_cnt_n == MAX_F) begin
                                state_n = ST_LOCKOUT;
                                timer_n = LOCK_LEN;
                            end
                        end
                    end
                end else if (!key_set && digit_ok) begin
                    entry_buf_n = {entry_buf[11:0], key_code};
                    entry_cnt_n = entry_cnt + 3'd1;
                end
            end
            ST_OPEN: begin
                if (door_close) begin
                    state_n     = ST_ENTRY;
                    entry_buf_n = '0;
                    entry_cnt_n = '0;
                end else if (key_clear) begin
                    entry_buf_n = '0;
                    entry_cnt_n = '0;
                end else if (!key_enter && key_set) begin
                    state_n     = ST_SET_PW;
                    entry_buf_n = '0;
                    entry_cnt_n = '0;
                end
            end
            ST_SET_PW: begin
                if (door_close) begin
                    state_n     = ST_ENTRY;
                    entry_buf_n = '0;
                    entry_cnt_n = '0;
                end else if (key_clear) begin
                    entry_buf_n = '0;
                    entry_cnt_n = '0;
                end else if (key_enter) begin
                    if (entry_cnt == 3'd4) begin
                        pw_n        = entry_buf;
                        entry_buf_n = '0;
                        entry_cnt_n = '0;
                        state_n     = ST_OPEN;
                    end
                end else if (!key_set && digit_ok) begin
                    entry_buf_n = {entry_buf[11:0], key_code};
                    entry_cnt_n = entry_cnt + 3'd1;
                end
            end
            default: begin
                // Expiry on timer==1 gives exactly LOCK_LEN cycles of alarm.
                timer_n = timer - 32'd1;
                if (timer <= 32'd1) begin
                    state_n     = ST_ENTRY;
                    timer_n     = '0;
                    fail_cnt_n  = '0;
                    entry_buf_n = '0;
                    entry_cnt_n = '0;
                end
            end
        endcase
    end

    always_comb begin
        case (state_n)
            ST_LOCKOUT: disp_n = 16'hEEEE;
            ST_OPEN:    disp_n = pw_n;
            default:    disp_n = entry_buf_n;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ENTRY;
            pw          <= DEFAULT_PW;
            entry_buf   <= '0;
            entry_cnt   <= '0;
            fail_cnt    <= '0;
            timer       <= '0;
            p0          <= '0;
            p1          <= '0;
            p2          <= '0;
            p3          <= '0;
            show_digits <= 1'b0;
            unlocked    <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            state       <= state_n;
            pw          <= pw_n;
            entry_buf   <= entry_buf_n;
            entry_cnt   <= entry_cnt_n;
            fail_cnt    <= fail_cnt_n;
            timer       <= timer_n;
            p0          <= disp_n[3:0];
            p1          <= disp_n[7:4];
            p2          <= disp_n[11:8];
            p3          <= disp_n[15:12];
            show_digits <= (state_n != ST_ENTRY);
            unlocked    <= (state_n == ST_OPEN) || (state_n == ST_SET_PW);
            alarm       <= (state_n == ST_LOCKOUT);
        end
    end

endmodule
